// File: rtl/excp_commit_pkg.sv
// Shared definitions for the commit stage: exception codes, CSR op
// encodings, translation-mode CSR numbers and the CSR exception bus layout.
package excp_commit_pkg;

  localparam int CSR_BUS_WD = 82;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [1:0] CSR_OP_NONE = 2'd0;
  localparam logic [1:0] CSR_OP_RD   = 2'd1;
  localparam logic [1:0] CSR_OP_WR   = 2'd2;
  localparam logic [1:0] CSR_OP_XCHG = 2'd3;

  localparam logic [13:0] CSR_CRMD = 14'h000;
  localparam logic [13:0] CSR_DMW0 = 14'h180;
  localparam logic [13:0] CSR_DMW1 = 14'h181;

  // Bit positions inside the per-instruction exception flag vector
  localparam int EXCP_ADEF = 0;
  localparam int EXCP_INE  = 1;
  localparam int EXCP_SYS  = 2;
  localparam int EXCP_BRK  = 3;
  localparam int EXCP_ALE  = 4;

  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  excp;
    logic [31:0] badv;
    logic        ertn;
    logic [1:0]  csr_op;
    logic [13:0] csr_num;
    logic [31:0] rd_val;
    logic [31:0] rj_val;
    logic [31:0] res;
  } buf_t;

  typedef struct packed {
    logic        is_etrn;
    logic        in_excp;
    logic [5:0]  ecode;
    logic [8:0]  subecode;
    logic [31:0] era;
    logic        use_badv;
    logic [31:0] badv;
  } csr_bus_t;

  // CSRXCHG: bits selected by mask come from rd, the rest keep the CSR value
  function automatic logic [31:0] xchg_merge(input logic [31:0] wd,
                                             input logic [31:0] cur,
                                             input logic [31:0] mask);
    return (wd & mask) | (cur & ~mask);
  endfunction

  // CSRs whose update changes address translation and needs a refetch
  function automatic logic is_mode_csr(input logic [13:0] num);
    return (num == CSR_CRMD) || (num == CSR_DMW0) || (num == CSR_DMW1);
  endfunction

endpackage

// File: rtl/excp_commit_prio.sv
// Priority resolver for interrupt and per-instruction exception flags.
// Interrupt beats every synchronous exception; among those ADEF is highest.
module excp_commit_prio
  import excp_commit_pkg::*;
(
  input  logic       have_intrpt_i,
  input  logic [4:0] excp_i,
  output logic       hit_o,
  output logic [5:0] ecode_o,
  output logic       use_badv_o,
  output logic       badv_sel_o   // 0: faulting pc, 1: data address
);

  // First matching source wins
  always_comb begin
    hit_o      = 1'b1;
    ecode_o    = ECODE_INT;
    use_badv_o = 1'b0;
    badv_sel_o = 1'b0;
    if (have_intrpt_i) begin
      ecode_o = ECODE_INT;
    end else if (excp_i[EXCP_ADEF]) begin
      ecode_o    = ECODE_ADEF;
      use_badv_o = 1'b1;
    end else if (excp_i[EXCP_INE]) begin
      ecode_o = ECODE_INE;
    end else if (excp_i[EXCP_SYS]) begin
      ecode_o = ECODE_SYS;
    end else if (excp_i[EXCP_BRK]) begin
      ecode_o = ECODE_BRK;
    end else if (excp_i[EXCP_ALE]) begin
      ecode_o    = ECODE_ALE;
      use_badv_o = 1'b1;
      badv_sel_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/excp_commit.sv
// Single-entry commit stage between EXE and WB. Owns the CSR write port and
// the exception bus, resolves exceptions/interrupts, performs CSR
// read-modify-write, and flushes the pipeline followed by a drain window.
module excp_commit
  import excp_commit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [4:0]            in_excp,
  input  logic [31:0]           in_badv,
  input  logic                  in_ertn,
  input  logic [1:0]            in_csr_op,
  input  logic [13:0]           in_csr_num,
  input  logic [31:0]           in_rd_val,
  input  logic [31:0]           in_rj_val,
  input  logic [31:0]           in_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_res,
  output logic [13:0]           csr_raddr,
  input  logic [31:0]           csr_rdata,
  output logic [13:0]           csr_waddr,
  output logic                  csr_wen,
  output logic [31:0]           csr_wdata,
  output logic [CSR_BUS_WD-1:0] csr_bus,
  input  logic                  have_intrpt,
  input  logic [31:0]           excp_pc,
  input  logic                  jump_excp_fail,
  output logic                  flush,
  output logic [31:0]           flush_pc
);

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       buf_valid_q, buf_valid_d;
  buf_t       buf_q, buf_d;

  logic       commit, accept, csr_wr_op;
  logic       hit, use_badv, badv_sel;
  logic [5:0] ecode;
  csr_bus_t   bus;

  excp_commit_prio u_prio (
    .have_intrpt_i (have_intrpt),
    .excp_i        (buf_q.excp),
    .hit_o         (hit),
    .ecode_o       (ecode),
    .use_badv_o    (use_badv),
    .badv_sel_o    (badv_sel)
  );

  assign commit    = buf_valid_q && out_ready;
  assign csr_wr_op = (buf_q.csr_op == CSR_OP_WR) || (buf_q.csr_op == CSR_OP_XCHG);
  // A handshake in the flush cycle belongs to a squashed younger instruction
  assign accept    = in_valid && in_ready && !flush;

  // Control state: FSM, drain counter and buffer occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Buffer payload; meaningful only while buf_valid_q is set
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Buffer load and occupancy next-state
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (commit) buf_valid_d = 1'b0;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_d = '{pc: in_pc, excp: in_excp, badv: in_badv, ertn: in_ertn,
                csr_op: in_csr_op, csr_num: in_csr_num, rd_val: in_rd_val,
                rj_val: in_rj_val, res: in_res};
    end
  end

  // RUN/DRAIN next-state: a flush opens a drain window of DRAIN_LOAD cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: all CSR side effects and flushes are qualified by commit
  always_comb begin
    in_ready  = (state_q == ST_RUN) && (!buf_valid_q || commit);
    out_valid = buf_valid_q;
    csr_raddr = buf_q.csr_num;
    csr_waddr = buf_q.csr_num;
    csr_wdata = (buf_q.csr_op == CSR_OP_XCHG) ?
                xchg_merge(buf_q.rd_val, csr_rdata, buf_q.rj_val) : buf_q.rd_val;
    // A CSR-file conflict blocks the write rather than corrupting state
    csr_wen   = commit && !hit && csr_wr_op && !jump_excp_fail;

    if (hit)                              out_res = '0;
    else if (buf_q.csr_op != CSR_OP_NONE) out_res = csr_rdata;
    else                                  out_res = buf_q.res;

    bus = '0;
    if (commit && (hit || buf_q.ertn)) begin
      bus.is_etrn  = !hit && buf_q.ertn;
      bus.in_excp  = hit;
      bus.ecode    = hit ? ecode : 6'd0;
      bus.subecode = '0;
      bus.era      = buf_q.pc;
      bus.use_badv = hit && use_badv;
      bus.badv     = (hit && use_badv) ? (badv_sel ? buf_q.badv : buf_q.pc) : 32'd0;
    end
    csr_bus = bus;

    flush    = commit && (hit || buf_q.ertn ||
                          (csr_wr_op && is_mode_csr(buf_q.csr_num)));
    flush_pc = (hit || buf_q.ertn) ? excp_pc : buf_q.pc + 32'd4;
  end

endmodule

// File: tb/tb_excp_commit.sv
// Directed bench for excp_commit: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares on every commit.
module tb_excp_commit;

  localparam int FC = 2;
  localparam logic [31:0] EPC = 32'h1C008000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_badv, in_rd_val, in_rj_val, in_res;
  logic [4:0]  in_excp;
  logic        in_ertn;
  logic [1:0]  in_csr_op;
  logic [13:0] in_csr_num;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wen;
  logic [81:0] csr_bus;
  logic        have_intrpt;
  logic [31:0] excp_pc;
  logic        jump_excp_fail;
  logic        flush;
  logic [31:0] flush_pc;

  excp_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_excp(in_excp), .in_badv(in_badv), .in_ertn(in_ertn),
    .in_csr_op(in_csr_op), .in_csr_num(in_csr_num), .in_rd_val(in_rd_val),
    .in_rj_val(in_rj_val), .in_res(in_res), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .csr_waddr(csr_waddr), .csr_wen(csr_wen),
    .csr_wdata(csr_wdata), .csr_bus(csr_bus), .have_intrpt(have_intrpt),
    .excp_pc(excp_pc), .jump_excp_fail(jump_excp_fail), .flush(flush),
    .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Fixed CSR contents seen on the read port
  always_comb begin
    case (csr_raddr)
      14'h030: csr_rdata = 32'h00000011;
      14'h031: csr_rdata = 32'h12345678;
      14'h032: csr_rdata = 32'h00000055;
      14'h000: csr_rdata = 32'h000000A8;
      default: csr_rdata = 32'h0;
    endcase
  end

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        wen;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [81:0] bus;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   flush_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  assert property (@(posedge clk) !jump_excp_fail);
  assert property (@(posedge clk) disable iff (rst) !(csr_wen && csr_bus[80]));

  function automatic logic [81:0] mk_bus(input logic etrn, input logic ex,
      input logic [5:0] ec, input logic [31:0] era, input logic ub,
      input logic [31:0] bv);
    return {etrn, ex, ec, 9'd0, era, ub, bv};
  endfunction

  task automatic chk(input string nm, input int id, input logic [81:0] act,
                     input logic [81:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: compare every commit against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) flush_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", -1, 82'(out_res), 82'hX);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_res", e.id, 82'(out_res), 82'(e.res));
          chk("csr_wen", e.id, 82'(csr_wen), 82'(e.wen));
          if (e.wen) begin
            chk("csr_waddr", e.id, 82'(csr_waddr), 82'(e.waddr));
            chk("csr_wdata", e.id, 82'(csr_wdata), 82'(e.wdata));
          end
          chk("csr_bus", e.id, csr_bus, e.bus);
          chk("flush", e.id, 82'(flush), 82'(e.fl));
          if (e.fl) chk("flush_pc", e.id, 82'(flush_pc), 82'(e.fpc));
          chk("wen_excp_excl", e.id, 82'(csr_wen && csr_bus[80]), 82'd0);
        end
      end else begin
        chk("idle_side_effects", -1, {csr_bus[79:0], csr_wen, flush}, 82'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [4:0] ex,
      input logic [31:0] bv, input logic ertn, input logic [1:0] op,
      input logic [13:0] num, input logic [31:0] rd, input logic [31:0] rj,
      input logic [31:0] res, input bit push, input exp_t e);
    int waited;
    in_valid = 1'b1; in_pc = pc; in_excp = ex; in_badv = bv; in_ertn = ertn;
    in_csr_op = op; in_csr_num = num; in_rd_val = rd; in_rj_val = rj; in_res = res;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) break;
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", e.id, 82'd0, 82'd1);
        break;
      end
    end
    acc_cyc = cyc;
    if (push && waited <= 50) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready && !out_valid) break;
      n++;
      if (n > 100) begin
        chk("idle_timeout", id, 82'd0, 82'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_flush(input int id);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (flush) break;
      n++;
      if (n > 50) begin
        chk("flush_timeout", id, 82'd0, 82'd1);
        break;
      end
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] res,
      input logic wen, input logic [13:0] wa, input logic [31:0] wd,
      input logic [81:0] bus, input logic fl, input logic [31:0] fpc);
    exp_t e;
    e.id = id; e.res = res; e.wen = wen; e.waddr = wa; e.wdata = wd;
    e.bus = bus; e.fl = fl; e.fpc = fpc;
    return e;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; have_intrpt = 1'b0;
    excp_pc = EPC; jump_excp_fail = 1'b0;
    in_pc = '0; in_excp = '0; in_badv = '0; in_ertn = 1'b0; in_csr_op = '0;
    in_csr_num = '0; in_rd_val = '0; in_rj_val = '0; in_res = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 0, 82'(out_valid), 82'd0);
    chk("rst_csr_wen", 0, 82'(csr_wen), 82'd0);
    chk("rst_flush", 0, 82'(flush), 82'd0);
    chk("rst_csr_bus", 0, csr_bus, 82'd0);
    chk("rst_in_ready", 0, 82'(in_ready), 82'd1);
    @(posedge clk); #1;

    // CSRWR SAVE0
    issue(32'h1C000000, 5'b0, 0, 0, 2'd2, 14'h030, 32'hDEADBEEF, 0, 32'h99, 1,
          mk(1, 32'h11, 1, 14'h030, 32'hDEADBEEF, 82'd0, 0, 0));
    wait_idle(1);
    // CSRXCHG
    issue(32'h1C000004, 5'b0, 0, 0, 2'd3, 14'h031, 32'hAAAA5555, 32'h0000FFFF, 0, 1,
          mk(2, 32'h12345678, 1, 14'h031, 32'h12345555, 82'd0, 0, 0));
    wait_idle(2);
    // CSRRD: read only
    issue(32'h1C000008, 5'b0, 0, 0, 2'd1, 14'h030, 32'hFFFFFFFF, 0, 0, 1,
          mk(3, 32'h11, 0, 0, 0, 82'd0, 0, 0));
    wait_idle(3);

    // SYS+ALE: SYS wins, CSR write suppressed, drain window
    issue(32'h1C000100, 5'b10100, 32'hBAD00000, 0, 2'd2, 14'h030, 32'h1, 0, 32'h77, 1,
          mk(4, 0, 0, 0, 0, mk_bus(0, 1, 6'h0B, 32'h1C000100, 0, 0), 1, EPC));
    wait_flush(4);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      chk("drain_in_ready", 4, 82'(in_ready), 82'd0);
    end
    @(negedge clk);
    chk("drain_end_in_ready", 4, 82'(in_ready), 82'd1);
    wait_idle(4);

    // ADEF with interrupt pending: INT wins
    have_intrpt = 1'b1;
    issue(32'h1C000003, 5'b00001, 0, 0, 2'd2, 14'h030, 32'h5, 0, 0, 1,
          mk(5, 0, 0, 0, 0, mk_bus(0, 1, 6'h00, 32'h1C000003, 0, 0), 1, EPC));
    wait_idle(5);
    have_intrpt = 1'b0;

    // ALE alone: badv is the data address
    issue(32'h1C000010, 5'b10000, 32'h00001235, 0, 2'd0, 0, 0, 0, 32'h3, 1,
          mk(6, 0, 0, 0, 0, mk_bus(0, 1, 6'h09, 32'h1C000010, 1, 32'h00001235), 1, EPC));
    wait_idle(6);
    // ADEF alone: badv is the pc
    issue(32'h1C000005, 5'b00001, 32'h0000AAAA, 0, 2'd0, 0, 0, 0, 0, 1,
          mk(7, 0, 0, 0, 0, mk_bus(0, 1, 6'h08, 32'h1C000005, 1, 32'h1C000005), 1, EPC));
    wait_idle(7);
    // INE+BRK: INE wins
    issue(32'h1C000020, 5'b01010, 0, 0, 2'd0, 0, 0, 0, 0, 1,
          mk(8, 0, 0, 0, 0, mk_bus(0, 1, 6'h0D, 32'h1C000020, 0, 0), 1, EPC));
    wait_idle(8);
    // BRK alone
    issue(32'h1C000024, 5'b01000, 0, 0, 2'd0, 0, 0, 0, 0, 1,
          mk(9, 0, 0, 0, 0, mk_bus(0, 1, 6'h0C, 32'h1C000024, 0, 0), 1, EPC));
    wait_idle(9);

    // ERTN then a back-to-back instruction held off until drain ends
    issue(32'h1C000200, 5'b0, 0, 1, 2'd0, 0, 0, 0, 0, 1,
          mk(10, 0, 0, 0, 0, mk_bus(1, 0, 6'h00, 32'h1C000200, 0, 0), 1, EPC));
    issue(32'h1C000204, 5'b0, 0, 0, 2'd0, 0, 0, 0, 32'h0000CAFE, 1,
          mk(11, 32'h0000CAFE, 0, 0, 0, 82'd0, 0, 0));
    chk("b2b_accept_cycle", 11, 82'(acc_cyc), 82'(flush_cyc + FC + 1));
    wait_idle(11);

    // CSRWR to CRMD refetches at pc+4
    issue(32'h1C000300, 5'b0, 0, 0, 2'd2, 14'h000, 32'h00000010, 0, 0, 1,
          mk(12, 32'hA8, 1, 14'h000, 32'h10, 82'd0, 1, 32'h1C000304));
    wait_idle(12);

    // Back-pressure: no side effects while WB stalls
    out_ready = 1'b0;
    issue(32'h1C000400, 5'b0, 0, 0, 2'd2, 14'h032, 32'h01020304, 0, 0, 1,
          mk(13, 32'h55, 1, 14'h032, 32'h01020304, 82'd0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_csr_wen", 13, 82'(csr_wen), 82'd0);
      chk("stall_in_ready", 13, 82'(in_ready), 82'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(13);

    // Reset with the buffer full drops the instruction
    out_ready = 1'b0;
    issue(32'h1C000500, 5'b0, 0, 0, 2'd2, 14'h030, 32'h9, 0, 0, 0,
          mk(14, 0, 0, 0, 0, 82'd0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_full_out_valid", 14, 82'(out_valid), 82'd0);
    chk("rst_full_in_ready", 14, 82'(in_ready), 82'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset in the middle of a drain window
    issue(32'h1C000600, 5'b00100, 0, 0, 2'd0, 0, 0, 0, 0, 1,
          mk(15, 0, 0, 0, 0, mk_bus(0, 1, 6'h0B, 32'h1C000600, 0, 0), 1, EPC));
    wait_flush(15);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drain_in_ready", 15, 82'(in_ready), 82'd1);
    chk("rst_drain_flush", 15, 82'(flush), 82'd0);
    chk("rst_drain_csr_wen", 15, 82'(csr_wen), 82'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 99, 82'(sb.size()), 82'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
